// File: rtl/ej32_pkg.sv
// Shared types for the eJ32 memory arbiter: owner tags, arbiter states and
// requester bit positions in the grant vector.
package ej32_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2,
    OWN_HS   = 2'd3
  } owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_st_t;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned REQ_IF  = 0;
  localparam int unsigned REQ_LS  = 1;
  localparam int unsigned REQ_HS  = 2;

  function automatic owner_t gnt_to_owner(input logic [NUM_REQ-1:0] gnt);
    owner_t own;
    unique case (gnt)
      3'b001:  own = OWN_IF;
      3'b010:  own = OWN_LS;
      3'b100:  own = OWN_HS;
      default: own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/ej32_arb_pick.sv
// Combinational priority select for the memory arbiter; produces a one-hot
// grant from the request vector, the arbiter state and the HS starvation flag.
module ej32_arb_pick
  import ej32_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  arb_st_t            i_state,
  input  logic               i_starved,
  output logic [NUM_REQ-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_state == ARB_LOCK) begin
      // A locked LS sequence owns the bus; idle cycles inside it grant nobody.
      o_gnt[REQ_LS] = i_req[REQ_LS];
    end else if (i_starved && i_req[REQ_HS]) begin
      o_gnt[REQ_HS] = 1'b1;
    end else if (i_req[REQ_LS]) begin
      o_gnt[REQ_LS] = 1'b1;
    end else if (i_req[REQ_IF]) begin
      o_gnt[REQ_IF] = 1'b1;
    end else if (i_req[REQ_HS]) begin
      o_gnt[REQ_HS] = 1'b1;
    end
  end

endmodule

// File: rtl/ej32_mem_arb.sv
// eJ32 memory bus arbiter: shares the byte-wide, one-cycle-latency memory
// between instruction fetch, load/store and the host console port.
module ej32_mem_arb
  import ej32_pkg::*;
#(
  parameter int unsigned ASZ    = 17,
  parameter int unsigned STARVE = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           if_req,
  input  logic [ASZ-1:0] if_addr,
  output logic           if_gnt,
  output logic           if_rvalid,
  input  logic           ls_req,
  input  logic           ls_we,
  input  logic           ls_lock,
  input  logic [ASZ-1:0] ls_addr,
  input  logic [7:0]     ls_wdata,
  output logic           ls_gnt,
  output logic           ls_rvalid,
  input  logic           hs_req,
  input  logic           hs_we,
  input  logic [ASZ-1:0] hs_addr,
  input  logic [7:0]     hs_wdata,
  output logic           hs_gnt,
  output logic           hs_rvalid,
  output logic [ASZ-1:0] mem_addr,
  output logic           mem_we,
  output logic [7:0]     mem_wdata,
  input  logic [7:0]     mem_rdata,
  output logic [7:0]     rdata,
  output owner_t         owner
);

  localparam int unsigned CW = $clog2(STARVE + 1);

  arb_st_t              r_state, w_state_d;
  logic    [CW-1:0]     r_starve_cnt, w_starve_cnt_d;
  owner_t               r_rv_owner, w_rv_owner_d;
  logic    [NUM_REQ-1:0] w_req, w_pick, w_gnt;
  logic                 w_starved;

  assign w_req     = {hs_req, ls_req, if_req};
  assign w_starved = (r_starve_cnt == CW'(STARVE));

  ej32_arb_pick u_pick (
    .i_req     (w_req),
    .i_state   (r_state),
    .i_starved (w_starved),
    .o_gnt     (w_pick)
  );

  // Nothing is granted or returned while reset is held.
  assign w_gnt  = rst_n ? w_pick : '0;
  assign if_gnt = w_gnt[REQ_IF];
  assign ls_gnt = w_gnt[REQ_LS];
  assign hs_gnt = w_gnt[REQ_HS];
  assign owner  = gnt_to_owner(w_gnt);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (owner)
      OWN_IF: mem_addr = if_addr;
      OWN_LS: begin
        mem_addr  = ls_addr;
        mem_we    = ls_we;
        mem_wdata = ls_wdata;
      end
      OWN_HS: begin
        mem_addr  = hs_addr;
        mem_we    = hs_we;
        mem_wdata = hs_wdata;
      end
      OWN_NONE: ;
    endcase
  end

  assign rdata     = mem_rdata;
  assign if_rvalid = rst_n && (r_rv_owner == OWN_IF);
  assign ls_rvalid = rst_n && (r_rv_owner == OWN_LS);
  assign hs_rvalid = rst_n && (r_rv_owner == OWN_HS);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ARB_IDLE: if (ls_gnt && ls_lock) w_state_d = ARB_LOCK;
      // In LOCK ls_gnt tracks ls_req, so dropping ls_lock always ends the sequence.
      ARB_LOCK: if (!ls_lock) w_state_d = ARB_IDLE;
      default:  w_state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_starve_cnt_d = '0;
    if (hs_req && !hs_gnt) begin
      w_starve_cnt_d = w_starved ? r_starve_cnt : r_starve_cnt + CW'(1);
    end
  end

  assign w_rv_owner_d = (owner != OWN_NONE && !mem_we) ? owner : OWN_NONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_starve_cnt <= '0;
      r_rv_owner   <= OWN_NONE;
    end else begin
      r_state      <= w_state_d;
      r_starve_cnt <= w_starve_cnt_d;
      r_rv_owner   <= w_rv_owner_d;
    end
  end

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Bench for ej32_mem_arb: a byte memory, a rule-level arbiter model checked on
// every cycle, and directed scenarios with hand-computed literal expectations.
module tb_ej32_mem_arb;

  localparam int unsigned ASZ    = 17;
  localparam int unsigned STARVE = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           if_req, ls_req, ls_we, ls_lock, hs_req, hs_we;
  logic [ASZ-1:0] if_addr, ls_addr, hs_addr;
  logic [7:0]     ls_wdata, hs_wdata;
  logic           if_gnt, ls_gnt, hs_gnt, if_rvalid, ls_rvalid, hs_rvalid;
  logic [ASZ-1:0] mem_addr;
  logic           mem_we;
  logic [7:0]     mem_wdata, rdata;
  logic [7:0]     mem_rdata = 8'h00;
  logic [1:0]     owner;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  ej32_mem_arb #(.ASZ(ASZ), .STARVE(STARVE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_lock   (ls_lock),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .hs_req    (hs_req),
    .hs_we     (hs_we),
    .hs_addr   (hs_addr),
    .hs_wdata  (hs_wdata),
    .hs_gnt    (hs_gnt),
    .hs_rvalid (hs_rvalid),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rdata     (rdata),
    .owner     (owner)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 7 + 3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory macro: one-cycle read latency, write on the clock edge.
  logic [7:0] env_mem [int];
  always @(posedge clk) begin
    int a;
    logic [7:0] rd;
    a  = int'(mem_addr);
    rd = env_mem.exists(a) ? env_mem[a] : init_val(a);
    mem_rdata <= rd;
    if (mem_we === 1'b1) env_mem[a] = mem_wdata;
  end

  // Rule-level model: who wins this cycle, and who owns the next read return.
  logic [7:0] exp_mem [int];
  logic       m_lock    = 1'b0;
  int         m_wait    = 0;
  logic [2:0] m_rv      = 3'b000;
  logic [7:0] m_rv_data = 8'h00;

  always @(negedge clk) begin
    logic [2:0]     eg;
    logic [ASZ-1:0] ea;
    logic           ewe;
    logic [7:0]     ewd;
    logic [1:0]     eown;
    eg = '0; ea = '0; ewe = 1'b0; ewd = '0; eown = '0;
    if (rst_n) begin
      if (m_lock)                          eg[1] = ls_req;
      else if (hs_req && m_wait >= STARVE) eg[2] = 1'b1;
      else if (ls_req)                     eg[1] = 1'b1;
      else if (if_req)                     eg[0] = 1'b1;
      else if (hs_req)                     eg[2] = 1'b1;
      if (eg[0]) begin ea = if_addr; eown = 2'd1; end
      if (eg[1]) begin ea = ls_addr; ewe = ls_we; ewd = ls_wdata; eown = 2'd2; end
      if (eg[2]) begin ea = hs_addr; ewe = hs_we; ewd = hs_wdata; eown = 2'd3; end
    end
    check("m_gnt", 32'({hs_gnt, ls_gnt, if_gnt}), 32'(eg));
    check("m_rvalid", 32'({hs_rvalid, ls_rvalid, if_rvalid}), 32'(rst_n ? m_rv : 3'b000));
    if (rst_n && m_rv != 3'b000) check("m_rdata", 32'(rdata), 32'(m_rv_data));
    check("m_owner", 32'(owner), 32'(eown));
    check("m_addr", 32'(mem_addr), 32'(ea));
    check("m_we", 32'(mem_we), 32'(ewe));
    check("m_wdata", 32'(mem_wdata), 32'(ewd));
    if (!rst_n) begin
      m_lock = 1'b0;
      m_wait = 0;
      m_rv   = 3'b000;
    end else begin
      m_rv = (eg != 3'b000 && !ewe) ? eg : 3'b000;
      if (eg != 3'b000 && !ewe)
        m_rv_data = exp_mem.exists(int'(ea)) ? exp_mem[int'(ea)] : init_val(int'(ea));
      if (eg != 3'b000 && ewe) exp_mem[int'(ea)] = ewd;
      m_lock = m_lock ? ls_lock : (eg[1] && ls_lock);
      m_wait = (hs_req && !eg[2]) ? ((m_wait < STARVE) ? m_wait + 1 : STARVE) : 0;
    end
  end

  task automatic clr();
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_lock = 1'b0; ls_addr = '0; ls_wdata = '0;
    hs_req = 1'b0; hs_we = 1'b0; hs_addr = '0; hs_wdata = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [7:0] lk_bytes [4] = '{8'h03, 8'h0A, 8'h11, 8'h18};

  initial begin
    clr();
    // Reset held with every requester asking.
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 17'h00010;
    ls_req = 1'b1; ls_addr = 17'h00200;
    hs_req = 1'b1; hs_addr = 17'h01000;
    for (int i = 0; i < 2; i++) begin
      smp();
      check("rst_gnt", 32'({hs_gnt, ls_gnt, if_gnt}), 0);
      check("rst_rvalid", 32'({hs_rvalid, ls_rvalid, if_rvalid}), 0);
      check("rst_we", 32'(mem_we), 0);
      check("rst_addr", 32'(mem_addr), 0);
      next();
    end
    rst_n = 1'b1;
    smp();
    check("rel_ls_gnt", 32'(ls_gnt), 1);
    check("rel_owner", 32'(owner), 2);
    next(); ls_req = 1'b0; smp();
    check("rel_if_gnt", 32'(if_gnt), 1);
    check("rel_ls_rvalid", 32'(ls_rvalid), 1);
    next(); if_req = 1'b0; smp();
    check("rel_hs_gnt", 32'(hs_gnt), 1);
    next(); clr(); smp();

    // IF beats HS; HS follows while IF data returns.
    next(); if_req = 1'b1; if_addr = 17'h00010; hs_req = 1'b1; hs_addr = 17'h01000; smp();
    check("pri_if_gnt", 32'(if_gnt), 1);
    check("pri_hs_wait", 32'(hs_gnt), 0);
    check("pri_addr", 32'(mem_addr), 'h10);
    next(); if_req = 1'b0; smp();
    check("pri_if_rvalid", 32'(if_rvalid), 1);
    check("pri_if_rdata", 32'(rdata), 'h73);
    check("pri_hs_gnt", 32'(hs_gnt), 1);
    check("pri_hs_addr", 32'(mem_addr), 'h1000);
    next(); hs_req = 1'b0; smp();
    check("pri_hs_rvalid", 32'(hs_rvalid), 1);
    check("pri_hs_rdata", 32'(rdata), 'h03);

    // Locked 4-byte LS read while IF keeps asking.
    next(); if_req = 1'b1; if_addr = 17'h00020; ls_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ls_addr = 17'(17'h00200 + i);
      ls_lock = (i < 3);
      smp();
      check("lk_ls_gnt", 32'(ls_gnt), 1);
      check("lk_if_gnt", 32'(if_gnt), 0);
      if (i > 0) begin
        check("lk_rvalid", 32'(ls_rvalid), 1);
        check("lk_rdata", 32'(rdata), 32'(lk_bytes[i-1]));
      end
      next();
    end
    ls_req = 1'b0; ls_lock = 1'b0; smp();
    check("lk_if_after", 32'(if_gnt), 1);
    check("lk_last_rdata", 32'(rdata), 32'(lk_bytes[3]));
    next(); if_req = 1'b0; smp();
    check("lk_if_rvalid", 32'(if_rvalid), 1);

    // Starvation: HS wins on cycle STARVE+1, and again STARVE+1 cycles later.
    next(); clr();
    ls_req = 1'b1; ls_addr = 17'h00300; if_req = 1'b1; if_addr = 17'h00030;
    hs_req = 1'b1; hs_addr = 17'h01010;
    for (int c = 1; c <= 18; c++) begin
      smp();
      check("stv_hs_gnt", 32'(hs_gnt), 32'(c == 9 || c == 18));
      check("stv_ls_gnt", 32'(ls_gnt), 32'(!(c == 9 || c == 18)));
      next();
    end
    clr();

    // HS write, then LS reads the byte back.
    next(); hs_req = 1'b1; hs_we = 1'b1; hs_addr = 17'h01400; hs_wdata = 8'h41; smp();
    check("wr_hs_gnt", 32'(hs_gnt), 1);
    check("wr_we", 32'(mem_we), 1);
    check("wr_wdata", 32'(mem_wdata), 'h41);
    check("wr_addr", 32'(mem_addr), 'h1400);
    next(); clr(); ls_req = 1'b1; ls_addr = 17'h01400; smp();
    check("wr_ls_gnt", 32'(ls_gnt), 1);
    check("wr_no_hs_rvalid", 32'(hs_rvalid), 0);
    check("wr_rd_we", 32'(mem_we), 0);
    next(); ls_req = 1'b0; smp();
    check("wr_ls_rvalid", 32'(ls_rvalid), 1);
    check("wr_readback", 32'(rdata), 'h41);

    // Reset after the second locked grant.
    next(); if_req = 1'b1; if_addr = 17'h00040; ls_req = 1'b1; ls_lock = 1'b1;
    ls_addr = 17'h00200; smp();
    check("rl_gnt1", 32'(ls_gnt), 1);
    next(); ls_addr = 17'h00201; smp();
    check("rl_gnt2", 32'(ls_gnt), 1);
    check("rl_if_blocked", 32'(if_gnt), 0);
    next(); rst_n = 1'b0; ls_req = 1'b0; ls_lock = 1'b0; smp();
    check("rl_rst_gnt", 32'({hs_gnt, ls_gnt, if_gnt}), 0);
    next(); rst_n = 1'b1; smp();
    check("rl_if_gnt", 32'(if_gnt), 1);
    check("rl_ls_rvalid", 32'(ls_rvalid), 0);
    next(); if_req = 1'b0; smp();
    check("rl_if_rvalid", 32'(if_rvalid), 1);
    check("rl_if_rdata", 32'(rdata), 'hC3);

    // Lock held across an idle LS cycle, then released with no access.
    next(); if_req = 1'b1; ls_req = 1'b1; ls_lock = 1'b1; ls_addr = 17'h00210; smp();
    check("hold_gnt", 32'(ls_gnt), 1);
    next(); ls_req = 1'b0; smp();
    check("hold_if_blocked", 32'(if_gnt), 0);
    next(); ls_lock = 1'b0; smp();
    check("rel_if_blocked", 32'(if_gnt), 0);
    next(); smp();
    check("rel_if_gnt2", 32'(if_gnt), 1);
    next(); clr(); smp();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
